json_speed_formatter: RTL and testbench

Formats a drive command with run-time left/right wheel speeds into the ASCII JSON line `{"T":<T>,"L":<l>,"R":<r>}\n`. It emits the line one byte at a time over a valid/ready byte stream that drives `uart_tx` directly. It sits upstream of the UART transmitter and replaces fixed-message senders with a speed-controllable source. Each accepted command produces exactly one complete line.

---
 rtl/json_cmd_pkg.sv | 34 +++
 rtl/bin2bcd_seq.sv | 62 ++++++
 rtl/json_speed_formatter.sv | 215 +++++++++++++++++++++
 tb/tb_json_speed_formatter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/json_cmd_pkg.sv
// Shared constants, state encoding and helpers for the JSON drive-command formatter.
// Contents: ASCII byte constants, FSM state enum, fixed field lengths,
//           and a BCD-digit to ASCII mapping function.
package json_cmd_pkg;

    localparam logic [7:0] ASCII_LBRACE = 8'h7B;
    localparam logic [7:0] ASCII_RBRACE = 8'h7D;
    localparam logic [7:0] ASCII_QUOTE  = 8'h22;
    localparam logic [7:0] ASCII_COLON  = 8'h3A;
    localparam logic [7:0] ASCII_COMMA  = 8'h2C;
    localparam logic [7:0] ASCII_MINUS  = 8'h2D;
    localparam logic [7:0] ASCII_NL     = 8'h0A;
    localparam logic [7:0] ASCII_ZERO   = 8'h30;
    localparam logic [7:0] ASCII_T      = 8'h54;
    localparam logic [7:0] ASCII_L      = 8'h4C;
    localparam logic [7:0] ASCII_R      = 8'h52;

    // {"T":NN,"L":  and  ,"R":
    localparam int unsigned PREFIX_LEN = 12;
    localparam int unsigned SEP_LEN    = 5;

    localparam int unsigned BCD_W = 12;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        EMIT
    } state_t;

    function automatic logic [7:0] bcd_to_ascii(input logic [3:0] d);
        return ASCII_ZERO | {4'h0, d};
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to 3-digit BCD converter, one bit per cycle.
// Ports: clk, rst (sync, active-high), start (loads bin), bin [IN_W],
//        bcd [12] (hundreds:tens:ones), busy, done (one-cycle pulse when bcd is valid).
// A conversion takes IN_W cycles counting the start cycle; bcd holds until the next start.
module bin2bcd_seq
    import json_cmd_pkg::*;
#(
    parameter int unsigned IN_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IN_W-1:0]   bin,
    output logic [BCD_W-1:0]  bcd,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = $clog2(IN_W + 1);

    logic [IN_W-1:0]  sreg;
    logic [CNT_W-1:0] cnt;
    logic [BCD_W-1:0] adj;

    // Add 3 to every digit that is 5 or more before the next shift
    always_comb begin
        adj = bcd;
        for (int d = 0; d < 3; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    // The start cycle already shifts in the MSB, so only IN_W-1 busy cycles follow
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
            bcd  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sreg <= bin << 1;
                bcd  <= {{(BCD_W-1){1'b0}}, bin[IN_W-1]};
                cnt  <= CNT_W'(1);
                busy <= 1'b1;
            end else if (busy) begin
                bcd  <= {adj[BCD_W-2:0], sreg[IN_W-1]};
                sreg <= sreg << 1;
                cnt  <= cnt + CNT_W'(1);
                if (cnt == CNT_W'(IN_W - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/json_speed_formatter.sv
// Formats a drive command into the ASCII line {"T":<T>,"L":<l>,"R":<r>}\n, one byte
// per valid/ready transfer, for direct connection to a UART transmitter.
// Ports: clk, rst (sync, active-high), cmd_valid/cmd_ready command handshake,
//        speed_l/speed_r signed speeds latched on accept, byte_data/byte_valid/byte_ready
//        byte stream, done one-cycle pulse after the final newline transfers.
module json_speed_formatter
    import json_cmd_pkg::*;
#(
    parameter int unsigned SPEED_W = 9,
    parameter int unsigned MAX_MAG = 255,
    parameter int unsigned CMD_T   = 11
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic signed [SPEED_W-1:0] speed_l,
    input  logic signed [SPEED_W-1:0] speed_r,
    output logic [7:0]                byte_data,
    output logic                      byte_valid,
    input  logic                      byte_ready,
    output logic                      done
);

    localparam int unsigned MAG_W = $clog2(MAX_MAG + 1);
    localparam int unsigned EXT_W = SPEED_W + 1;
    localparam int unsigned IDX_W = 5;

    localparam logic [7:0] T_TENS = bcd_to_ascii(4'(CMD_T / 10));
    localparam logic [7:0] T_ONES = bcd_to_ascii(4'(CMD_T % 10));

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt, last_idx;
    logic [IDX_W-1:0]   l_end, r_start, r_end;
    logic               done_nxt, conv_start, conv_done;
    logic               neg_l, neg_r;
    logic [MAG_W-1:0]   mag_l, mag_r;
    logic [BCD_W-1:0]   bcd_l, bcd_r;
    logic               busy_l, busy_r, cdone_l, cdone_r;
    logic [2:0]         len_l, len_r;

    // Negate in one extra bit so the most-negative input has a representable magnitude
    function automatic logic [MAG_W-1:0] clamp_mag(input logic signed [SPEED_W-1:0] s);
        logic signed [EXT_W-1:0] ext;
        logic [EXT_W-1:0]        mag;
        ext = {s[SPEED_W-1], s};
        mag = s[SPEED_W-1] ? $unsigned(-ext) : $unsigned(ext);
        if (mag > EXT_W'(MAX_MAG)) begin
            return MAG_W'(MAX_MAG);
        end
        return MAG_W'(mag);
    endfunction

    // Text length of a number: sign plus digits with leading zeros suppressed
    function automatic logic [2:0] num_len(input logic neg, input logic [BCD_W-1:0] bcd);
        logic [2:0] nd;
        if (bcd[11:8] != 4'd0)     nd = 3'd3;
        else if (bcd[7:4] != 4'd0) nd = 3'd2;
        else                       nd = 3'd1;
        return nd + 3'(neg);
    endfunction

    // Character k of a number; digits are addressed from the right end of the text
    function automatic logic [7:0] num_char(input logic neg, input logic [BCD_W-1:0] bcd,
                                            input logic [2:0] len, input logic [2:0] k);
        logic [2:0] sel;
        logic [7:0] c;
        sel = len - 3'd1 - k;
        case (sel)
            3'd2:    c = bcd_to_ascii(bcd[11:8]);
            3'd1:    c = bcd_to_ascii(bcd[7:4]);
            default: c = bcd_to_ascii(bcd[3:0]);
        endcase
        if (neg && k == 3'd0) begin
            c = ASCII_MINUS;
        end
        return c;
    endfunction

    function automatic logic [7:0] prefix_char(input logic [3:0] i);
        case (i)
            4'd0:    return ASCII_LBRACE;
            4'd1:    return ASCII_QUOTE;
            4'd2:    return ASCII_T;
            4'd3:    return ASCII_QUOTE;
            4'd4:    return ASCII_COLON;
            4'd5:    return T_TENS;
            4'd6:    return T_ONES;
            4'd7:    return ASCII_COMMA;
            4'd8:    return ASCII_QUOTE;
            4'd9:    return ASCII_L;
            4'd10:   return ASCII_QUOTE;
            default: return ASCII_COLON;
        endcase
    endfunction

    function automatic logic [7:0] sep_char(input logic [2:0] i);
        case (i)
            3'd0:    return ASCII_COMMA;
            3'd1:    return ASCII_QUOTE;
            3'd2:    return ASCII_R;
            3'd3:    return ASCII_QUOTE;
            default: return ASCII_COLON;
        endcase
    endfunction

    assign mag_l = clamp_mag(speed_l);
    assign mag_r = clamp_mag(speed_r);

    bin2bcd_seq #(.IN_W(MAG_W)) u_bcd_l (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (mag_l),
        .bcd   (bcd_l),
        .busy  (busy_l),
        .done  (cdone_l)
    );

    bin2bcd_seq #(.IN_W(MAG_W)) u_bcd_r (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (mag_r),
        .bcd   (bcd_r),
        .busy  (busy_r),
        .done  (cdone_r)
    );

    assign conv_done = cdone_l && cdone_r && !busy_l && !busy_r;

    // Field boundaries within the line
    assign len_l    = num_len(neg_l, bcd_l);
    assign len_r    = num_len(neg_r, bcd_r);
    assign l_end    = IDX_W'(PREFIX_LEN) + IDX_W'(len_l);
    assign r_start  = l_end + IDX_W'(SEP_LEN);
    assign r_end    = r_start + IDX_W'(len_r);
    assign last_idx = r_end + IDX_W'(1);

    // Next-state logic
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        done_nxt   = 1'b0;
        conv_start = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    conv_start = 1'b1;
                    state_nxt  = CONV;
                end
            end
            CONV: begin
                if (conv_done) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (byte_valid && byte_ready) begin
                    if (idx == last_idx) begin
                        idx_nxt   = '0;
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and handshake registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            byte_valid <= 1'b0;
            cmd_ready  <= 1'b1;
            done       <= 1'b0;
            neg_l      <= 1'b0;
            neg_r      <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            byte_valid <= (state_nxt == EMIT);
            cmd_ready  <= (state_nxt == IDLE);
            done       <= done_nxt;
            if (conv_start) begin
                neg_l <= speed_l[SPEED_W-1];
                neg_r <= speed_r[SPEED_W-1];
            end
        end
    end

    // Byte selection from the current index and latched fields
    always_comb begin
        byte_data = 8'h00;
        if (state == EMIT) begin
            if (idx < IDX_W'(PREFIX_LEN))
                byte_data = prefix_char(4'(idx));
            else if (idx < l_end)
                byte_data = num_char(neg_l, bcd_l, len_l, 3'(idx - IDX_W'(PREFIX_LEN)));
            else if (idx < r_start)
                byte_data = sep_char(3'(idx - l_end));
            else if (idx < r_end)
                byte_data = num_char(neg_r, bcd_r, len_r, 3'(idx - r_start));
            else if (idx == r_end)
                byte_data = ASCII_RBRACE;
            else
                byte_data = ASCII_NL;
        end
    end

endmodule

// File: tb/tb_json_speed_formatter.sv
// Directed bench for json_speed_formatter: expected lines are written out by hand.
module tb_json_speed_formatter;

    localparam int unsigned SPEED_W = 10;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic signed [SPEED_W-1:0] speed_l;
    logic signed [SPEED_W-1:0] speed_r;
    logic [7:0]                byte_data;
    logic                      byte_valid;
    logic                      byte_ready;
    logic                      done;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    json_speed_formatter #(
        .SPEED_W (SPEED_W),
        .MAX_MAG (255),
        .CMD_T   (11)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .speed_l    (speed_l),
        .speed_r    (speed_r),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // 0: always ready, 1: random stalls, 2: slow UART (one ready cycle in 40)
    function automatic logic ready_pattern(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return ($urandom_range(0, 2) != 0);
            default: return ((cyc % 40) == 39);
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge
    task automatic start_cmd(input int l, input int r, input bit hold);
        cmd_valid = 1'b1;
        speed_l   = SPEED_W'(l);
        speed_r   = SPEED_W'(r);
        check("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = hold;
        speed_l   = SPEED_W'(301);
        speed_r   = SPEED_W'(-301);
    endtask

    task automatic wait_first();
        int lat = 0;
        while (!byte_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'd8);
        check("first_byte", 32'(byte_data), 32'h7B);
    endtask

    task automatic collect(input string exp, input int mode, input bit hold_next,
                           input int nl, input int nr);
        int         i = 0;
        int         cyc = 0;
        bit         stalled = 1'b0;
        logic [7:0] held = 8'h00;
        while (i < exp.len() && cyc < 5000) begin
            if (stalled) begin
                check("hold_valid", 32'(byte_valid), 32'd1);
                check("hold_data", 32'(byte_data), 32'(held));
            end
            check("no_early_done", 32'(done), 32'd0);
            byte_ready = ready_pattern(mode, cyc);
            if (byte_valid && byte_ready) begin
                check($sformatf("byte%0d", i), 32'(byte_data), 32'(exp[i]));
                if (hold_next && i == exp.len() - 1) begin
                    speed_l = SPEED_W'(nl);
                    speed_r = SPEED_W'(nr);
                end
                i++;
                stalled = 1'b0;
            end else begin
                stalled = byte_valid;
                held    = byte_data;
            end
            @(negedge clk);
            cyc++;
        end
        byte_ready = 1'b1;
        check("line_complete", 32'(i), 32'(exp.len()));
        check("done_pulse", 32'(done), 32'd1);
        check("valid_after_line", 32'(byte_valid), 32'd0);
        check("ready_after_line", 32'(cmd_ready), 32'd1);
        check("data_idle", 32'(byte_data), 32'h00);
        if (!hold_next) begin
            @(negedge clk);
            check("done_once", 32'(done), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string pfx;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        speed_l    = '0;
        speed_r    = '0;
        byte_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(byte_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_data", 32'(byte_data), 32'h00);
        rst = 1'b0;
        byte_ready = 1'b1;
        @(negedge clk);

        start_cmd(164, 164, 1'b0);
        wait_first();
        collect("{\"T\":11,\"L\":164,\"R\":164}\n", 0, 1'b0, 0, 0);

        start_cmd(0, -5, 1'b0);
        wait_first();
        collect("{\"T\":11,\"L\":0,\"R\":-5}\n", 0, 1'b0, 0, 0);

        start_cmd(-256, 300, 1'b0);
        wait_first();
        collect("{\"T\":11,\"L\":-255,\"R\":255}\n", 0, 1'b0, 0, 0);

        start_cmd(99, -100, 1'b0);
        wait_first();
        collect("{\"T\":11,\"L\":99,\"R\":-100}\n", 1, 1'b0, 0, 0);

        start_cmd(-512, 255, 1'b0);
        wait_first();
        collect("{\"T\":11,\"L\":-255,\"R\":255}\n", 2, 1'b0, 0, 0);

        // Abort a line with reset after seven bytes have transferred
        pfx = "{\"T\":11";
        start_cmd(164, 164, 1'b0);
        wait_first();
        byte_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            check($sformatf("abort_byte%0d", k), 32'(byte_data), 32'(pfx[k]));
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_valid", 32'(byte_valid), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        check("abort_no_done", 32'(done), 32'd0);

        start_cmd(1, 2, 1'b0);
        wait_first();
        collect("{\"T\":11,\"L\":1,\"R\":2}\n", 0, 1'b0, 0, 0);

        // cmd_valid held high: junk speeds during the line, new speeds on the done cycle
        start_cmd(10, -20, 1'b1);
        wait_first();
        collect("{\"T\":11,\"L\":10,\"R\":-20}\n", 0, 1'b1, 7, -8);
        @(negedge clk);
        cmd_valid = 1'b0;
        speed_l   = SPEED_W'(301);
        speed_r   = SPEED_W'(-301);
        check("held_done_once", 32'(done), 32'd0);
        check("held_accepted", 32'(cmd_ready), 32'd0);
        wait_first();
        collect("{\"T\":11,\"L\":7,\"R\":-8}\n", 0, 1'b0, 0, 0);

        repeat (3) @(negedge clk);
        check("final_idle_valid", 32'(byte_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
